// File: rtl/loader_pkg.sv
// Shared types and default constants for the instruction-memory loader.
package loader_pkg;

    // Default loader parameters: PC stride, largest accepted image, byte-gap limit.
    localparam int DEF_ADDR_STEP      = 4;
    localparam int DEF_MAX_WORDS      = 16384;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    // Loader FSM states, in stream order.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN_HI  = 3'd1,
        ST_LEN_LO  = 3'd2,
        ST_DATA_HI = 3'd3,
        ST_DATA_LO = 3'd4,
        ST_CHECK   = 3'd5,
        ST_DONE    = 3'd6,
        ST_ERROR   = 3'd7
    } state_e;

    // Failure reason reported on err_code.
    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_LEN     = 2'd1,
        ERR_CSUM    = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_e;

    // True in the states that take bytes from the stream.
    function automatic logic is_receiving(input state_e s);
        return s inside {ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO, ST_CHECK};
    endfunction

endpackage

// File: rtl/loader_timer.sv
// Byte-gap watchdog: counts enabled cycles since the last clear and flags
// when the count reaches TIMEOUT_CYCLES.
module loader_timer
    import loader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int             CW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] count_q;

    // Gap counter: cleared on request, saturates at the limit while enabled.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && (count_q != LIMIT)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired = enable && (count_q == LIMIT);

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed, XOR-checksummed program image into instruction
// memory one 16-bit word at a time, holding the CPU in reset until the image
// has been fully received and verified.
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_STEP      = DEF_ADDR_STEP,
    parameter int MAX_WORDS      = DEF_MAX_WORDS,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [15:0] wr_data,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code,
    output logic [15:0] words_loaded
);

    localparam logic [31:0] MAX_WORDS_U = 32'(MAX_WORDS);
    localparam logic [15:0] ADDR_STEP_U = 16'(ADDR_STEP);

    // FSM and datapath state.
    state_e      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [7:0]  hi_q, hi_d;
    logic [7:0]  csum_q, csum_d;
    logic [15:0] words_q, words_d;
    err_code_e   err_q, err_d;
    logic        wr_en_q, wr_en_d;
    logic [15:0] wr_addr_q, wr_addr_d;
    logic [15:0] wr_data_q, wr_data_d;

    // Registered status flags, decoded from the next state.
    logic        recv_q;
    logic        done_q;
    logic        error_q;
    logic        hold_q;

    logic        accept;
    logic        start_ok;
    logic        expired;
    logic        timer_clear;
    logic [15:0] len_rx;
    logic        len_bad;
    logic [15:0] words_next;
    logic        last_word;

    // A byte moves only when the source offers it and we are in a receiving state.
    assign accept      = in_valid & recv_q;
    assign start_ok    = start & (state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
    assign len_rx      = {len_q[15:8], in_data};
    assign len_bad     = (len_rx == 16'd0) || ({16'd0, len_rx} > MAX_WORDS_U);
    assign words_next  = words_q + 16'd1;
    assign last_word   = (words_next == len_q);
    // The gap count restarts on every byte and is held at zero outside a load,
    // so it is already zero when LEN_HI is entered.
    assign timer_clear = accept | ~recv_q;

    loader_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (recv_q),
        .expired (expired)
    );

    // Next-state and datapath update for one stream byte per cycle.
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        hi_d      = hi_q;
        csum_d    = csum_q;
        words_d   = words_q;
        err_d     = err_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_ok) begin
                    state_d = ST_LEN_HI;
                    err_d   = ERR_NONE;
                    words_d = 16'd0;
                    csum_d  = 8'd0;
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    len_d   = {in_data, 8'h00};
                    state_d = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    len_d = len_rx;
                    if (len_bad) begin
                        state_d = ST_ERROR;
                        err_d   = ERR_LEN;
                    end else begin
                        state_d = ST_DATA_HI;
                    end
                end
            end
            ST_DATA_HI: begin
                if (accept) begin
                    hi_d    = in_data;
                    csum_d  = csum_q ^ in_data;
                    state_d = ST_DATA_LO;
                end
            end
            ST_DATA_LO: begin
                if (accept) begin
                    csum_d    = csum_q ^ in_data;
                    wr_en_d   = 1'b1;
                    wr_data_d = {hi_q, in_data};
                    wr_addr_d = words_q * ADDR_STEP_U;
                    words_d   = words_next;
                    state_d   = last_word ? ST_CHECK : ST_DATA_HI;
                end
            end
            ST_CHECK: begin
                if (accept) begin
                    if (in_data == csum_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ERROR;
                        err_d   = ERR_CSUM;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A stalled stream aborts the load; a byte arriving on the same edge wins.
        if (recv_q && !accept && expired) begin
            state_d = ST_ERROR;
            err_d   = ERR_TIMEOUT;
        end
    end

    // State, datapath and registered status outputs.
    // NOTE: this design holds no memory arrays, so every flop here can safely take the reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            len_q     <= 16'd0;
            hi_q      <= 8'd0;
            csum_q    <= 8'd0;
            words_q   <= 16'd0;
            err_q     <= ERR_NONE;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 16'd0;
            wr_data_q <= 16'd0;
            recv_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            hold_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            hi_q      <= hi_d;
            csum_q    <= csum_d;
            words_q   <= words_d;
            err_q     <= err_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            recv_q    <= is_receiving(state_d);
            done_q    <= (state_d == ST_DONE);
            error_q   <= (state_d == ST_ERROR);
            hold_q    <= (state_d != ST_DONE);
        end
    end

    assign in_ready     = recv_q;
    assign busy         = recv_q;
    assign done         = done_q;
    assign error        = error_q;
    assign cpu_hold     = hold_q;
    assign err_code     = err_q;
    assign words_loaded = words_q;
    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a table of whole-stream vectors plus
// hand-written sequences for start-while-busy, timeout and mid-load reset.
module tb_imem_loader;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        start    = 1'b0;
    logic [7:0]  in_data  = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;
    logic [15:0] words_loaded;

    imem_loader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .err_code     (err_code),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit rand_gaps = 1'b0;

    typedef logic [7:0]  byte_arr_t [10];
    typedef logic [15:0] word_arr_t [3];

    typedef struct {
        string     name;
        int        nbytes;
        byte_arr_t bytes;
        int        nwords;
        word_arr_t data;
        logic      exp_done;
        logic      exp_error;
        logic [1:0] exp_code;
        logic      exp_hold;
    } vec_t;

    vec_t vecs [6];

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t wr_q [$];

    // Record every memory write; wr_en is a one-cycle strobe so one negedge sees it.
    always @(negedge clk) begin
        if (wr_en === 1'b1) wr_q.push_back('{addr: wr_addr, data: wr_data});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input string nm, input int nb, input byte_arr_t b,
                           input int nw, input word_arr_t d, input logic dn, input logic er,
                           input logic [1:0] cd, input logic hold);
        vecs[i].name      = nm;
        vecs[i].nbytes    = nb;
        vecs[i].bytes     = b;
        vecs[i].nwords    = nw;
        vecs[i].data      = d;
        vecs[i].exp_done  = dn;
        vecs[i].exp_error = er;
        vecs[i].exp_code  = cd;
        vecs[i].exp_hold  = hold;
    endtask

    // Called at a negedge; start is seen by exactly one rising edge.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; offers one byte and returns at the negedge after it moves.
    task automatic send_byte(input logic [7:0] b);
        int budget;
        bit taken;
        if (rand_gaps) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom_range(0, 255));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        in_data  = b;
        in_valid = 1'b1;
        taken    = 1'b0;
        budget   = 0;
        while (!taken && budget < 20) begin
            if (in_ready === 1'b1) begin
                @(posedge clk);
                taken = 1'b1;
            end
            @(negedge clk);
            budget++;
        end
        in_valid = 1'b0;
        checks++;
        if (!taken) begin
            errors++;
            $display("FAIL byte_accept: byte 0x%0h not taken, in_ready=%0b", b, in_ready);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        check({tag, "_wr_data"}, 32'(wr_data), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_err_code"}, 32'(err_code), 32'd0);
        check({tag, "_words"}, 32'(words_loaded), 32'd0);
    endtask

    // Watchdog so a stuck run still ends.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        set_vec(0, "good", 7, '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40, 8'h00, 8'h00, 8'h00},
                2, '{16'h1234, 16'hABCD, 16'h0000}, 1'b1, 1'b0, 2'd0, 1'b0);
        set_vec(1, "bad_csum", 7, '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41, 8'h00, 8'h00, 8'h00},
                2, '{16'h1234, 16'hABCD, 16'h0000}, 1'b0, 1'b1, 2'd2, 1'b1);
        set_vec(2, "len_zero", 2, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                0, '{16'h0000, 16'h0000, 16'h0000}, 1'b0, 1'b1, 2'd1, 1'b1);
        set_vec(3, "len_over", 2, '{8'h40, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                0, '{16'h0000, 16'h0000, 16'h0000}, 1'b0, 1'b1, 2'd1, 1'b1);
        set_vec(4, "one_word", 5, '{8'h00, 8'h01, 8'hBE, 8'hEF, 8'h51, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                1, '{16'hBEEF, 16'h0000, 16'h0000}, 1'b1, 1'b0, 2'd0, 1'b0);
        set_vec(5, "three_words", 9, '{8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h00},
                3, '{16'h0102, 16'h0304, 16'h0506}, 1'b1, 1'b0, 2'd0, 1'b0);

        // Reset state
        repeat (2) @(negedge clk);
        check_reset_values("por");
        reset = 1'b0;
        @(negedge clk);

        // Table of whole streams
        rand_gaps = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_q.delete();
            pulse_start();
            check({vecs[i].name, "_start_busy"}, 32'(busy), 32'd1);
            check({vecs[i].name, "_start_ready"}, 32'(in_ready), 32'd1);
            check({vecs[i].name, "_start_done"}, 32'(done), 32'd0);
            check({vecs[i].name, "_start_error"}, 32'(error), 32'd0);
            check({vecs[i].name, "_start_code"}, 32'(err_code), 32'd0);
            check({vecs[i].name, "_start_words"}, 32'(words_loaded), 32'd0);
            check({vecs[i].name, "_start_hold"}, 32'(cpu_hold), 32'd1);
            for (int b = 0; b < vecs[i].nbytes; b++) send_byte(vecs[i].bytes[b]);
            repeat (2) @(negedge clk);
            check({vecs[i].name, "_done"}, 32'(done), 32'(vecs[i].exp_done));
            check({vecs[i].name, "_error"}, 32'(error), 32'(vecs[i].exp_error));
            check({vecs[i].name, "_code"}, 32'(err_code), 32'(vecs[i].exp_code));
            check({vecs[i].name, "_hold"}, 32'(cpu_hold), 32'(vecs[i].exp_hold));
            check({vecs[i].name, "_words"}, 32'(words_loaded), 32'(vecs[i].nwords));
            check({vecs[i].name, "_busy"}, 32'(busy), 32'd0);
            check({vecs[i].name, "_ready"}, 32'(in_ready), 32'd0);
            check({vecs[i].name, "_nwrites"}, 32'(wr_q.size()), 32'(vecs[i].nwords));
            for (int k = 0; k < vecs[i].nwords && k < wr_q.size(); k++) begin
                check({vecs[i].name, "_addr"}, 32'(wr_q[k].addr), 32'(k * 4));
                check({vecs[i].name, "_data"}, 32'(wr_q[k].data), 32'(vecs[i].data[k]));
            end
        end

        // Start while in DATA_HI is ignored
        wr_q.delete();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        pulse_start();
        check("midstart_busy", 32'(busy), 32'd1);
        check("midstart_words", 32'(words_loaded), 32'd1);
        send_byte(8'hAB);
        send_byte(8'hCD);
        send_byte(8'h40);
        repeat (2) @(negedge clk);
        check("midstart_done", 32'(done), 32'd1);
        check("midstart_hold", 32'(cpu_hold), 32'd0);
        check("midstart_words_end", 32'(words_loaded), 32'd2);
        check("midstart_nwrites", 32'(wr_q.size()), 32'd2);
        if (wr_q.size() == 2) begin
            check("midstart_data0", 32'(wr_q[0].data), 32'h1234);
            check("midstart_addr1", 32'(wr_q[1].addr), 32'h0004);
            check("midstart_data1", 32'(wr_q[1].data), 32'hABCD);
        end

        // Byte-gap timeout after 00 01 12
        rand_gaps = 1'b0;
        wr_q.delete();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h12);
        repeat (1000) @(negedge clk);
        check("timeout_early_error", 32'(error), 32'd0);
        check("timeout_early_busy", 32'(busy), 32'd1);
        begin
            int waited = 0;
            while (error !== 1'b1 && waited < 100) begin
                @(negedge clk);
                waited++;
            end
        end
        check("timeout_error", 32'(error), 32'd1);
        check("timeout_code", 32'(err_code), 32'd3);
        check("timeout_ready", 32'(in_ready), 32'd0);
        check("timeout_hold", 32'(cpu_hold), 32'd1);
        check("timeout_nwrites", 32'(wr_q.size()), 32'd0);

        // Reset in the middle of a load
        wr_q.delete();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        @(negedge clk);
        check("midreset_first_write", 32'(wr_q.size()), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("midreset");
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hAB;
        repeat (8) @(negedge clk);
        in_valid = 1'b0;
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_ready", 32'(in_ready), 32'd0);
        check("midreset_words", 32'(words_loaded), 32'd0);
        check("midreset_nwrites", 32'(wr_q.size()), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
